// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and parity-type constants.
package uart_pkg;

  // Receiver frame FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Parity type selectors
  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

endpackage : uart_pkg

// File: rtl/uart_rx_frame_if.sv
// Serial-receive bundle between a UART line driver and the frame receiver.
//   RX_IN            serial line, idle high
//   P_DATA_OUT_RX    last good received word
//   DATA_VALID_RX    1-cycle pulse on a good frame
//   parity_error_RX  1-cycle pulse on a parity mismatch
//   stop_error_RX    1-cycle pulse on a stop bit sampled low
// master: the line-driving / result-consuming side; slave: the receiver.
interface uart_rx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  RX_IN;
  logic [DATA_WIDTH-1:0] P_DATA_OUT_RX;
  logic                  DATA_VALID_RX;
  logic                  parity_error_RX;
  logic                  stop_error_RX;

  modport master (
    output RX_IN,
    input  P_DATA_OUT_RX,
    input  DATA_VALID_RX,
    input  parity_error_RX,
    input  stop_error_RX
  );

  modport slave (
    input  RX_IN,
    output P_DATA_OUT_RX,
    output DATA_VALID_RX,
    output parity_error_RX,
    output stop_error_RX
  );

endinterface : uart_rx_frame_if

// File: rtl/uart_rx_sampler.sv
// Line front end for the UART receiver: 2-flop synchronizer, falling-edge
// detect and the per-bit oversampling counter with mid-bit / wrap strobes.
//   i_clk      receiver clock (N x baud)
//   i_rst_n    synchronous active-low reset
//   i_rx       raw asynchronous serial line
//   i_run      keep the bit counter running (low holds it at 0)
//   o_rx_s     synchronized line value
//   o_fall_c   synchronized line fell this cycle
//   o_mid_c    counter is at the mid-bit sample point
//   o_wrap_c   counter is at the last cycle of the bit
module uart_rx_sampler #(
  parameter int unsigned N = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  input  logic i_run,
  output logic o_rx_s,
  output logic o_fall_c,
  output logic o_mid_c,
  output logic o_wrap_c
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;

  // Synchronizer, edge-detect history and oversampling counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!i_run || o_wrap_c) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rx_s   = r_sync2;
  assign o_fall_c = !r_sync2 && r_prev;
  assign o_mid_c  = (r_cnt == CNT_W'(N / 2));
  assign o_wrap_c = (r_cnt == CNT_W'(N - 1));

endmodule : uart_rx_sampler

// File: rtl/uart_rx_frame.sv
// UART frame receiver: recovers start/data/parity/stop frames from an
// oversampled serial line and reports the word or the frame error.
//   rx_clk   receiver clock (N x baud)
//   rst      synchronous active-low reset
//   bus      slave side of uart_rx_frame_if: RX_IN in; P_DATA_OUT_RX,
//            DATA_VALID_RX, parity_error_RX, stop_error_RX out (all registered)
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAR_EN     = 1,
  parameter int unsigned PAR_TYPE   = PAR_EVEN,
  parameter int unsigned N          = 4
) (
  input  logic            rx_clk,
  input  logic            rst,
  uart_rx_frame_if.slave  bus
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt_nxt;
  logic                  r_par_err;
  logic                  w_par_err_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_perr;
  logic                  w_perr_nxt;
  logic                  r_serr;
  logic                  w_serr_nxt;

  logic w_rx_s;
  logic w_fall;
  logic w_mid;
  logic w_wrap;
  logic w_run;
  logic w_par_odd;

  assign w_par_odd = (PAR_TYPE == PAR_ODD);

  // Counter runs for every cycle the frame FSM will be active next
  assign w_run = (w_state_nxt != ST_IDLE);

  uart_rx_sampler #(
    .N (N)
  ) u_sampler (
    .i_clk    (rx_clk),
    .i_rst_n  (rst),
    .i_rx     (bus.RX_IN),
    .i_run    (w_run),
    .o_rx_s   (w_rx_s),
    .o_fall_c (w_fall),
    .o_mid_c  (w_mid),
    .o_wrap_c (w_wrap)
  );

  // State and datapath registers
  always_ff @(posedge rx_clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_err <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_serr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par_err <= w_par_err_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_perr    <= w_perr_nxt;
      r_serr    <= w_serr_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_err_nxt = r_par_err;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_perr_nxt    = 1'b0;
    w_serr_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt   = ST_START;
          w_bit_cnt_nxt = '0;
          w_par_err_nxt = 1'b0;
        end
      end

      ST_START: begin
        // A start bit that reads high at mid-bit was a glitch
        if (w_mid && w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wrap) begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_mid) begin
          w_shift_nxt = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
        end
        if (w_wrap) begin
          if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            w_state_nxt = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (w_mid) begin
          w_par_err_nxt = (w_rx_s != ((^r_shift) ^ w_par_odd));
        end
        if (w_wrap) begin
          w_state_nxt = ST_STOP;
        end
      end

      ST_STOP: begin
        // Leave at mid-bit so a start edge right after the stop bit is caught
        if (w_mid) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = w_rx_s && !r_par_err;
          w_perr_nxt  = r_par_err;
          w_serr_nxt  = !w_rx_s;
          if (w_rx_s && !r_par_err) begin
            w_data_nxt = r_shift;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.P_DATA_OUT_RX   = r_data;
  assign bus.DATA_VALID_RX   = r_valid;
  assign bus.parity_error_RX = r_perr;
  assign bus.stop_error_RX   = r_serr;

endmodule : uart_rx_frame

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a transmitter model drives frames, a
// scoreboard queue holds the expected pulse (kind, word, cycle) per frame.
module tb_uart_rx_frame;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  localparam logic [2:0] F_VALID = 3'b100;
  localparam logic [2:0] F_PERR  = 3'b010;
  localparam logic [2:0] F_SERR  = 3'b001;

  typedef struct packed {
    logic [2:0]  flags;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  last_good = 8'h00;
  exp_t        exp_q[$];

  uart_rx_frame_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_frame #(
    .DATA_WIDTH (DW),
    .PAR_EN     (1),
    .PAR_TYPE   (0),
    .N          (N)
  ) dut (
    .rx_clk (clk),
    .rst    (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return p;
  endfunction

  // Transmitter model: start, 8 data bits LSB first, parity, stop; each bit N cycles.
  // nbits < 11 sends only the first nbits bits (aborted frame, no expectation).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic [2:0] flags, input int nbits);
    logic [10:0] bits;
    exp_t        e;
    bits = {stp, par, d, 1'b0};
    if (nbits == 11) begin
      if (flags == F_VALID) last_good = d;
      e.flags = flags;
      e.data  = last_good;
      e.cyc   = cyc + 45;
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      bus.RX_IN = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every pulse must match the oldest expected frame outcome
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.DATA_VALID_RX || bus.parity_error_RX || bus.stop_error_RX)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, bus.DATA_VALID_RX, bus.parity_error_RX, bus.stop_error_RX}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_flags", {29'd0, bus.DATA_VALID_RX, bus.parity_error_RX, bus.stop_error_RX},
              {29'd0, e.flags});
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_data", {24'd0, bus.P_DATA_OUT_RX}, {24'd0, e.data});
      end
    end
  end

  initial begin
    bus.RX_IN = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data",  {24'd0, bus.P_DATA_OUT_RX}, 32'h0);
    check("reset_valid", {31'd0, bus.DATA_VALID_RX}, 32'h0);
    check("reset_perr",  {31'd0, bus.parity_error_RX}, 32'h0);
    check("reset_serr",  {31'd0, bus.stop_error_RX}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Good frame
    send_frame(8'hA5, even_par(8'hA5), 1'b1, F_VALID, 11);
    idle(6);

    // Wrong parity: word must be held
    send_frame(8'h3C, ~even_par(8'h3C), 1'b1, F_PERR, 11);
    idle(6);
    check("held_after_perr", {24'd0, bus.P_DATA_OUT_RX}, 32'hA5);

    // Stop error, line then stays low: no new frame may start
    send_frame(8'h0F, even_par(8'h0F), 1'b0, F_SERR, 11);
    repeat (24) @(negedge clk);
    idle(8);
    check("held_after_serr", {24'd0, bus.P_DATA_OUT_RX}, 32'hA5);

    // Parity and stop errors together
    send_frame(8'h01, ~even_par(8'h01), 1'b0, F_PERR | F_SERR, 11);
    idle(8);

    // One-cycle glitch, then a good frame
    bus.RX_IN = 1'b0;
    @(negedge clk);
    idle(12);
    send_frame(8'h5A, even_par(8'h5A), 1'b1, F_VALID, 11);
    idle(6);
    check("after_glitch", {24'd0, bus.P_DATA_OUT_RX}, 32'h5A);

    // Back-to-back frames: pulse cycles 44 apart via the expected-cycle check
    send_frame(8'h55, even_par(8'h55), 1'b1, F_VALID, 11);
    send_frame(8'hAA, even_par(8'hAA), 1'b1, F_VALID, 11);
    idle(8);

    // Reset during DATA: frame is abandoned
    send_frame(8'hC3, even_par(8'hC3), 1'b1, F_VALID, 5);
    bus.RX_IN = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("midframe_reset_data", {24'd0, bus.P_DATA_OUT_RX}, 32'h0);
    rst_n = 1'b1;
    last_good = 8'h00;
    idle(50);
    check("no_pulse_aborted", {31'd0, bus.DATA_VALID_RX}, 32'h0);
    send_frame(8'h81, even_par(8'h81), 1'b1, F_VALID, 11);
    idle(10);
    check("final_data", {24'd0, bus.P_DATA_OUT_RX}, 32'h81);
    check("all_pulses_seen", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx_frame
